// File: rtl/right_shift_seq.sv
// Sequential 8-bit right shifter/rotator with a start/done handshake.
// Define RIGHT_SHIFT_MULTISTEP_EN to shift up to three positions per SHIFT cycle.
module right_shift_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] mode,
  input  logic [2:0] amount,
  input  logic [7:0] I,
  output logic [7:0] out,
  output logic       busy,
  output logic       done,
  output logic [1:0] o_dbg_state
);

  // Handshake: start is sampled on a rising edge only in IDLE or DONE; done is a
  // one-cycle pulse during which out is valid; start seen during SHIFT is dropped.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t      r_state;
  logic [7:0]  r_work;
  logic [2:0]  r_cnt;
  logic [1:0]  r_mode;
  logic        r_sign;
  logic [7:0]  r_out;
  logic        r_busy;
  logic        r_done;

  logic [2:0]  w_step;
  logic [7:0]  w_fill;
  logic [15:0] w_cat;
  logic [15:0] w_sh;
  logic [7:0]  w_next;
  logic [2:0]  w_cnt_next;

`ifdef RIGHT_SHIFT_MULTISTEP_EN
  assign w_step = (r_cnt > 3'd3) ? 3'd3 : r_cnt;
`else
  assign w_step = 3'd1;
`endif

  // The upper byte supplies the bits that enter from the left; for rotate it is
  // the word itself, so a plain right shift of the pair yields the rotation.
  always_comb begin
    w_fill = 8'h00;
    case (r_mode)
      2'b00:   w_fill = r_work;
      2'b10:   w_fill = {8{r_sign}};
      default: w_fill = 8'h00;
    endcase
    w_cat      = {w_fill, r_work};
    w_sh       = w_cat >> w_step;
    w_next     = w_sh[7:0];
    w_cnt_next = r_cnt - w_step;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_work  <= 8'h00;
      r_cnt   <= 3'd0;
      r_mode  <= 2'b00;
      r_sign  <= 1'b0;
      r_out   <= 8'h00;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_work <= I;
            r_cnt  <= amount;
            r_mode <= mode;
            r_sign <= I[7];
            if (amount != 3'd0) begin
              r_state <= ST_SHIFT;
              r_busy  <= 1'b1;
            end else begin
              r_state <= ST_DONE;
              r_out   <= I;
              r_done  <= 1'b1;
            end
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          r_work <= w_next;
          r_cnt  <= w_cnt_next;
          if (w_cnt_next == 3'd0) begin
            r_state <= ST_DONE;
            r_out   <= w_next;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign out         = r_out;
  assign busy        = r_busy;
  assign done        = r_done;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_right_shift_seq.sv
// Directed bench for right_shift_seq; expectations follow RIGHT_SHIFT_MULTISTEP_EN when defined.
module tb_right_shift_seq;

  logic       clk;
  logic       rst;
  logic       start;
  logic [1:0] mode;
  logic [2:0] amount;
  logic [7:0] I;
  logic [7:0] out;
  logic       busy;
  logic       done;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q[$];

  right_shift_seq dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .amount(amount),
    .I(I), .out(out), .busy(busy), .done(done), .o_dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int exp_lat(input int n);
`ifdef RIGHT_SHIFT_MULTISTEP_EN
    return (n + 2) / 3;
`else
    return n;
`endif
  endfunction

  // Called #1 after an edge; advances edge by edge until done, bounded.
  task automatic wait_done(input string tag, output int edges, output int busy_cyc);
    logic [7:0] e;
    edges = 0;
    busy_cyc = 0;
    while (!done && edges < 40) begin
      if (busy) busy_cyc++;
      @(posedge clk); #1;
      edges++;
    end
    if (done) begin
      check({tag, "_busy_done_excl"}, {31'd0, busy}, 32'd0);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      check({tag, "_out"}, {24'd0, out}, {24'd0, e});
    end else begin
      check({tag, "_timeout"}, 32'd1, 32'd0);
    end
  endtask

  task automatic drive_start(input logic [7:0] i, input logic [1:0] md, input logic [2:0] amt);
    start = 1'b1; I = i; mode = md; amount = amt;
  endtask

  task automatic do_op(input string tag, input logic [7:0] i, input logic [1:0] md,
                       input logic [2:0] amt, input logic [7:0] exp);
    int edges, bc;
    @(negedge clk);
    drive_start(i, md, amt);
    exp_q.push_back(exp);
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(tag, edges, bc);
    check({tag, "_lat"}, edges, exp_lat(amt));
    check({tag, "_busy_cycles"}, bc, exp_lat(amt));
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int edges, bc, dcount;
    start = 1'b0; mode = 2'b00; amount = 3'd0; I = 8'h00;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out", {24'd0, out}, 32'h00);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_state", {30'd0, dbg_state}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    do_op("rot81_1",   8'h81, 2'b00, 3'd1, 8'hC0);
    do_op("logF0_3",   8'hF0, 2'b01, 3'd3, 8'h1E);
    do_op("ari80_2",   8'h80, 2'b10, 3'd2, 8'hE0);
    do_op("m11_80_2",  8'h80, 2'b11, 3'd2, 8'h20);
    do_op("amt0_A5",   8'hA5, 2'b00, 3'd0, 8'hA5);
    do_op("rot01_7",   8'h01, 2'b00, 3'd7, 8'h02);
    do_op("rot6C_4",   8'h6C, 2'b00, 3'd4, 8'hC6);
    do_op("ari96_3",   8'h96, 2'b10, 3'd3, 8'hF2);
    do_op("ariB4_7",   8'hB4, 2'b10, 3'd7, 8'hFF);
    do_op("ari34_2",   8'h34, 2'b10, 3'd2, 8'h0D);
    do_op("log3C_7",   8'h3C, 2'b01, 3'd7, 8'h00);
    do_op("rotA5_5",   8'hA5, 2'b00, 3'd5, 8'h2D);

    // out holds after return to IDLE
    repeat (3) @(posedge clk);
    #1;
    check("hold_out", {24'd0, out}, 32'h2D);
    check("idle_state", {30'd0, dbg_state}, 32'd0);

    // start during SHIFT is ignored
    @(negedge clk);
    drive_start(8'hF0, 2'b01, 3'd5);
    exp_q.push_back(8'h07);
    @(posedge clk); #1;
    start = 1'b0;
    check("ign_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    drive_start(8'hFF, 2'b00, 3'd1);
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("ignore", edges, bc);
    check("ign_lat", edges + 1, exp_lat(5));
    dcount = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done) dcount++;
    end
    check("ign_extra_done", dcount, 0);

    // asynchronous reset mid-SHIFT
    @(negedge clk);
    drive_start(8'hA5, 2'b01, 3'd6);
    @(posedge clk); #1;
    start = 1'b0;
    check("abort_busy_pre", {31'd0, busy}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_out", {24'd0, out}, 32'h00);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_state", {30'd0, dbg_state}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    dcount = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done) dcount++;
    end
    check("abort_no_done", dcount, 0);
    do_op("post_rst", 8'hF0, 2'b01, 3'd3, 8'h1E);

    // back-to-back: start reissued while done is high
    @(negedge clk);
    drive_start(8'h81, 2'b00, 3'd1);
    exp_q.push_back(8'hC0);
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("b2b_first", edges, bc);
    check("b2b_first_lat", edges, exp_lat(1));
    drive_start(8'h01, 2'b00, 3'd7);
    exp_q.push_back(8'h02);
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b_no_idle_busy", {31'd0, busy}, 32'd1);
    check("b2b_state", {30'd0, dbg_state}, 32'd1);
    wait_done("b2b_second", edges, bc);
    check("b2b_second_lat", edges, exp_lat(7));
    check("b2b_second_busy", bc, exp_lat(7));
    check("exp_q_empty", exp_q.size(), 0);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/right_shift_seq.md
# right_shift_seq

Sequential right shifter/rotator for 8-bit data: the right-direction counterpart of the team's combinational left-rotate stage. It accepts an operand and a shift amount of 0–7 through a start/done handshake. It then shifts the working register right by one position per clock (or up to three with the multistep option) and presents a registered result with a one-cycle `done` pulse. It sits in the datapath next to the left rotator, wherever a variable right shift is needed and single-cycle barrel logic is not wanted.

## Interface
- No parameters; width fixed at 8 bits, amount fixed at 3 bits.
- `clk`  input  1  system clock, rising-edge active
- `rst`  input  1  reset, asynchronous, active-high
- `start`  input  1  request; sampled on rising edge of `clk`
- `mode`  input  2  00 rotate right, 01 logical right (zero fill), 10 arithmetic right (sign fill), 11 treated as 01
- `amount`  input  3  shift distance 0–7
- `I`  input  8  operand
- `out`  output  8  result register
- `busy`  output  1  high while in SHIFT
- `done`  output  1  one-cycle pulse, `out` valid

## Operation
- States: IDLE, SHIFT, DONE.
- Internal registers: `work[7:0]`, `cnt[2:0]`, `mode_r[1:0]`, `sign_r` (= `I[7]` at load).
- **Accepting a request.** `start` is accepted only in IDLE or DONE. On acceptance:
  - `work<=I`, `cnt<=amount`, `mode_r<=mode`, `sign_r<=I[7]`.
  - Next state is SHIFT if `amount!=0`, else DONE with `out<=I`.
- **Ignored requests.** `start` during SHIFT is ignored. It is not queued, and the inputs are not re-sampled.
- **SHIFT step.** Each edge in SHIFT does the following:
  - `step=1` (without the macro).
  - `work` shifts right by `step`.
  - Vacated MSBs are filled with the LSBs shifted out (rotate), 0 (logical), or `sign_r` (arithmetic).
  - `cnt<=cnt-step`.
  - When `cnt-step==0`, the next state is DONE and `out` is loaded with the post-shift `work` value.
- **DONE.** `done=1` for exactly one cycle. Next state is IDLE unless `start` is sampled, in which case it is accepted as above (back-to-back operation).
- **Result holding.** `out` holds its value until the next load into DONE. It is not cleared on return to IDLE.
- **Inputs.** `I`, `mode` and `amount` need only be valid on the accepting edge.
- **Reset.**
  - `rst` high forces IDLE immediately and asynchronously.
  - `out=8'h00`, `busy=0`, `done=0`, `work=0`, `cnt=0`.
  - Reset mid-SHIFT aborts the operation; no `done` is produced.

## Timing
- Call the accepting edge E0.
- `amount=0`: `done` is high in the cycle after E0, so latency is 1 cycle.
- `amount=n>0` (base build):
  - `busy` is high for n cycles after E0.
  - `done` is high after edge E0+n, so latency is n+1 cycles.
- `busy` and `done` are never high together. `busy` is 0 in IDLE and DONE.
- Throughput with back-to-back requests (start held/reissued in DONE): one result per n+1 cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- Macro: `RIGHT_SHIFT_MULTISTEP_EN`.
- **Defined:**
  - `step=min(cnt,3)` per SHIFT cycle; `cnt` decrements by `step`.
  - A 4:1 mux per bit selects the 0/1/2/3 shifted value, with fill applied per mode.
  - Latency is ceil(n/3)+1 cycles for n>0. Example: n=7 gives 3 SHIFT cycles and `done` after E0+3.
- **Undefined:**
  - `step=1` always, with a 2:1 mux per bit.
  - Latency n+1.
- Ports and handshake are identical in both builds.

## Test plan
- Rotate: `I=8'h81`, `amount=1`, `mode=00` → `out=8'hC0`, `done` pulse 2 cycles after E0, `busy` high 1 cycle.
- Logical shift: `I=8'hF0`, `amount=3` → `out=8'h1E`. Arithmetic shift: `I=8'h80`, `amount=2`, `mode=10` → `out=8'hE0`. With `mode=11`, `I=8'h80`, `amount=2` → `out=8'h20`.
- `amount=0`, `I=8'hA5` → `out=8'hA5`, `done` the cycle after E0, `busy` never high.
- `start` pulsed again mid-SHIFT with different `I`/`amount` → ignored. Original result delivered, exactly one `done`.
- `rst` asserted during SHIFT, between edges → `busy`, `out` and `done` go to 0 immediately. No `done` follows; the next `start` works normally.
- With `RIGHT_SHIFT_MULTISTEP_EN`: `I=8'h01`, `amount=7`, `mode=00` → `out=8'h02`, `busy` 3 cycles, `done` 4 cycles after E0. Back-to-back start in DONE is accepted with no IDLE cycle.
